twofish_key_sched: RTL and testbench
====================================

# twofish_key_sched

Sequential Twofish round-subkey generator for 128-bit keys. It sits directly downstream of the q-permutation boxes: a single shared h-function datapath, built from q0/q1 byte permutations, the MDS multiply and the PHT mix, is time-multiplexed to produce the 40 expanded subkeys K0..K39 as 20 word pairs. The pairs stream with a valid/ready handshake into the round-key store used by the cipher core. The S-vector (RS code) is computed elsewhere.

## Interface
- No parameters; key length is fixed at 128 bits (k = 2).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request expansion; sampled only in IDLE.
- key  in  128  user key; byte m_j = key[8j+7:8j]; sampled on accepted start.
- busy  out  1  high in every state except IDLE.
- k_valid  out  1  subkey pair presented.
- k_ready  in  1  consumer accepts the pair.
- k_idx  out  5  pair index i, 0..19.
- k_even  out  32  K(2i).
- k_odd  out  32  K(2i+1).
- done  out  1  one-cycle pulse after pair 19 is accepted.

## Operation
- Key words are little-endian: M_j = {m(4j+3), m(4j+2), m(4j+1), m(4j)}. Me = (M0, M2) and Mo = (M1, M3). List element 0 is L0 and element 1 is L1.
- h(X, L) for k = 2, per byte y_n of X:
  - y0 = q1[q0[q0[y0]^l1_0]^l0_0]
  - y1 = q0[q0[q1[y1]^l1_1]^l0_1]
  - y2 = q1[q1[q0[y2]^l1_2]^l0_2]
  - y3 = q0[q1[q1[y3]^l1_3]^l0_3]
  - The result is then multiplied by the MDS matrix over GF(2^8), polynomial 0x169.
  - MDS rows: [01 EF 5B 5B], [5B EF EF 01], [EF 5B 01 EF], [EF 01 EF 5B].
  - Output Z = z0 + z1·2^8 + z2·2^16 + z3·2^24.
- Per pair i (ρ = 0x01010101):
  - A = h(2i·ρ, Me)
  - B = ROL(h((2i+1)·ρ, Mo), 8)
  - K2i = (A + B) mod 2^32
  - K2i+1 = ROL((A + 2B) mod 2^32, 9)
  - All sums are 32-bit and discard the carry.
- FSM states:
  - IDLE: on start, latch key, set i = 0, go to CALC_A.
  - CALC_A: register A, go to CALC_B.
  - CALC_B: register B and compute both K words into output registers, go to OUT.
  - OUT: hold k_valid = 1 and the outputs stable until k_ready. On handshake, if i = 19 go to IDLE and pulse done; otherwise i <= i + 1 and go to CALC_A.
- start while busy is ignored. The latched key is unaffected by later changes on the key input.
- Reset mid-expansion aborts immediately. There is no partial output and no done pulse.

## Timing
- Reset values: state IDLE; busy 0; k_valid 0; done 0; k_idx 0; k_even 0; k_odd 0; A/B and key registers 0.
- Start accepted at edge 0. CALC_A runs in cycle 1 and CALC_B in cycle 2. k_valid rises in cycle 3.
- Each pair costs 3 cycles plus stall cycles. With k_ready held at 1, all 60 cycles complete and done pulses in the cycle after the final handshake, together with busy falling.
- k_ready is ignored when k_valid = 0. k_idx/k_even/k_odd must not change while k_valid = 1 and k_ready = 0.
- There is one h evaluation per cycle, so the combinational path is 3 q layers plus MDS.

## Structure
- Package twofish_pkg holds:
  - MDS coefficient constants, RHO = 32'h01010101, and the GF(2^8) polynomial 0x169.
  - A gf_mul function and a rol32 function.
  - The state enum {IDLE, CALC_A, CALC_B, OUT}.
- Sub-module h_func is combinational: inputs x[31:0], l0[31:0], l1[31:0]; output z[31:0]. It instantiates 12 qBox (q = 0/1 per byte path) plus the MDS. The top level holds the FSM, counter, registers and PHT.

## Test plan
- All-zero key, k_ready = 1 -> pair 0 reads k_even = 32'h52C54DDE and k_odd = 32'h11F0626D, with k_valid in cycle 3 after start.
- All-zero key, full run -> 20 pairs with k_idx 0..19 in order, one done pulse in the cycle after pair 19, and 60 cycles from start to the last handshake.
- Random keys, compared against a software Twofish reference -> all 40 words match.
- k_ready held low 5 cycles on pair 7 -> outputs stay stable, the pair is accepted on the first cycle k_ready = 1, and the remaining values are unchanged.
- start pulsed with a different key during pair 3 -> ignored, and the original key's subkeys continue.
- rst asserted during CALC_B of pair 10 -> all outputs return to their reset values asynchronously with no done pulse; a new start after reset begins again at k_idx = 0.

Source files
------------

// File: rtl/twofish_pkg.sv
// rtl/twofish_pkg.sv - shared constants, GF(2^8) helpers and FSM states for the Twofish key schedule
package twofish_pkg;

  localparam logic [31:0] RHO      = 32'h01010101;
  localparam logic [8:0]  GF_POLY  = 9'h169;
  localparam logic [4:0]  LAST_IDX = 5'd19;

  localparam logic [7:0] MDS_01 = 8'h01;
  localparam logic [7:0] MDS_5B = 8'h5B;
  localparam logic [7:0] MDS_EF = 8'hEF;

  localparam logic [7:0] MDS_M [4][4] = '{
    '{MDS_01, MDS_EF, MDS_5B, MDS_5B},
    '{MDS_5B, MDS_EF, MDS_EF, MDS_01},
    '{MDS_EF, MDS_5B, MDS_01, MDS_EF},
    '{MDS_EF, MDS_01, MDS_EF, MDS_5B}
  };

  // q-permutation nibble tables, entry 0 in the least significant nibble
  localparam logic [63:0] Q0_T0 = 64'h4ACE_95B0_23F6_D718;
  localparam logic [63:0] Q0_T1 = 64'hD907_6A4F_5321_8BCE;
  localparam logic [63:0] Q0_T2 = 64'h1742_3F8C_09D6_E5AB;
  localparam logic [63:0] Q0_T3 = 64'hAC58_03B9_E621_4F7D;
  localparam logic [63:0] Q1_T0 = 64'h5CA0_4913_E67F_DB82;
  localparam logic [63:0] Q1_T1 = 64'h809F_5AD6_73C4_B2E1;
  localparam logic [63:0] Q1_T2 = 64'hF3B2_8DE0_A961_57C4;
  localparam logic [63:0] Q1_T3 = 64'hA802_F746_ED3C_159B;

  typedef enum logic [1:0] {IDLE, CALC_A, CALC_B, OUT} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ GF_POLY[7:0]) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

endpackage

// File: rtl/twofish_key_sched_h_func.sv
// rtl/twofish_key_sched_h_func.sv - Twofish h-function for a two-word key list (three q layers plus MDS)
module h_func
  import twofish_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] l0,
  input  logic [31:0] l1,
  output logic [31:0] z
);

  // q selection per byte lane, bit 3n+s is the q used by stage s of lane n
  localparam logic [11:0] Q_ORDER = {3'b011, 3'b110, 3'b001, 3'b100};

  logic [31:0] w_y;

  for (genvar n = 0; n < 4; n++) begin : g_lane
    logic [7:0] w_s1, w_s2, w_s3;
    qBox #(.Q(Q_ORDER[3*n+0])) u_q_s1 (.i_x(x[8*n +: 8]),           .o_y(w_s1));
    qBox #(.Q(Q_ORDER[3*n+1])) u_q_s2 (.i_x(w_s1 ^ l1[8*n +: 8]),   .o_y(w_s2));
    qBox #(.Q(Q_ORDER[3*n+2])) u_q_s3 (.i_x(w_s2 ^ l0[8*n +: 8]),   .o_y(w_s3));
    assign w_y[8*n +: 8] = w_s3;
  end

  always_comb begin
    z = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        z[8*r +: 8] = z[8*r +: 8] ^ gf_mul(MDS_M[r][c], w_y[8*c +: 8]);
      end
    end
  end

endmodule

// File: rtl/twofish_key_sched_qbox.sv
// rtl/twofish_key_sched_qbox.sv - combinational Twofish q0/q1 byte permutation
module qBox
  import twofish_pkg::*;
#(
  parameter bit Q = 1'b0
) (
  input  logic [7:0] i_x,
  output logic [7:0] o_y
);

  localparam logic [63:0] T0 = Q ? Q1_T0 : Q0_T0;
  localparam logic [63:0] T1 = Q ? Q1_T1 : Q0_T1;
  localparam logic [63:0] T2 = Q ? Q1_T2 : Q0_T2;
  localparam logic [63:0] T3 = Q ? Q1_T3 : Q0_T3;

  logic [3:0] w_a0, w_b0, w_a1, w_b1, w_a2, w_b2, w_a3, w_b3, w_a4, w_b4;

  assign w_a0 = i_x[7:4];
  assign w_b0 = i_x[3:0];
  // each round: mix nibbles (rotate-right-by-1 and 8*a mod 16), then substitute
  assign w_a1 = w_a0 ^ w_b0;
  assign w_b1 = w_a0 ^ {w_b0[0], w_b0[3:1]} ^ {w_a0[0], 3'b000};
  assign w_a2 = T0[{w_a1, 2'b00} +: 4];
  assign w_b2 = T1[{w_b1, 2'b00} +: 4];
  assign w_a3 = w_a2 ^ w_b2;
  assign w_b3 = w_a2 ^ {w_b2[0], w_b2[3:1]} ^ {w_a2[0], 3'b000};
  assign w_a4 = T2[{w_a3, 2'b00} +: 4];
  assign w_b4 = T3[{w_b3, 2'b00} +: 4];
  assign o_y  = {w_b4, w_a4};

endmodule

// File: rtl/twofish_key_sched.sv
// rtl/twofish_key_sched.sv - sequential 128-bit Twofish subkey generator, one h evaluation per cycle
module twofish_key_sched
  import twofish_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         k_valid,
  input  logic         k_ready,
  output logic [4:0]   k_idx,
  output logic [31:0]  k_even,
  output logic [31:0]  k_odd,
  output logic         done
);

  state_t        r_state, w_next;
  logic [127:0]  r_key;
  logic [4:0]    r_idx;
  logic [31:0]   r_a, r_even, r_odd;
  logic          r_done;

  logic          w_sel_b, w_last, w_hs;
  logic [7:0]    w_xb;
  logic [31:0]   w_x, w_l0, w_l1, w_z, w_b, w_sum, w_sum2;

  assign w_sel_b = (r_state == CALC_B);
  assign w_last  = (r_idx == LAST_IDX);
  assign w_hs    = (r_state == OUT) && k_ready;

  // CALC_A evaluates h(2i*rho, Me); CALC_B evaluates h((2i+1)*rho, Mo)
  assign w_xb = {2'b00, r_idx, w_sel_b};
  assign w_x  = RHO * {24'd0, w_xb};
  assign w_l0 = w_sel_b ? r_key[63:32]   : r_key[31:0];
  assign w_l1 = w_sel_b ? r_key[127:96]  : r_key[95:64];

  h_func u_h (.x(w_x), .l0(w_l0), .l1(w_l1), .z(w_z));

  assign w_b    = rol32(w_z, 5'd8);
  assign w_sum  = r_a + w_b;
  assign w_sum2 = r_a + {w_b[30:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CALC_A;
      CALC_A:  w_next = CALC_B;
      CALC_B:  w_next = OUT;
      OUT:     if (k_ready) w_next = w_last ? IDLE : CALC_A;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key  <= '0;
      r_idx  <= '0;
      r_a    <= '0;
      r_even <= '0;
      r_odd  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_hs && w_last;
      case (r_state)
        IDLE: if (start) begin
          r_key <= key;
          r_idx <= '0;
        end
        CALC_A: r_a <= w_z;
        CALC_B: begin
          r_even <= w_sum;
          r_odd  <= rol32(w_sum2, 5'd9);
        end
        OUT: if (k_ready && !w_last) r_idx <= r_idx + 5'd1;
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign k_valid = (r_state == OUT);
  assign k_idx   = r_idx;
  assign k_even  = r_even;
  assign k_odd   = r_odd;
  assign done    = r_done;

endmodule

// File: tb/tb_twofish_key_sched.sv
// tb/tb_twofish_key_sched.sv - randomized self-checking bench against a table-driven Twofish key schedule model
module tb_twofish_key_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic         k_ready = 1'b0;
  logic         busy, k_valid, done;
  logic [4:0]   k_idx;
  logic [31:0]  k_even, k_odd;

  int n_checks = 0;
  int n_fail   = 0;

  twofish_key_sched dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .busy(busy),
    .k_valid(k_valid), .k_ready(k_ready), .k_idx(k_idx),
    .k_even(k_even), .k_odd(k_odd), .done(done)
  );

  always #5 clk = ~clk;

  int QT [2][4][16] = '{
    '{'{8,1,7,13,6,15,3,2,0,11,5,9,14,12,10,4}, '{14,12,11,8,1,2,3,5,15,4,10,6,7,0,9,13},
      '{11,10,5,14,6,13,9,0,12,8,15,3,2,4,7,1}, '{13,7,15,4,1,2,6,14,9,11,3,0,8,5,12,10}},
    '{'{2,8,11,13,15,7,6,14,3,1,9,4,0,10,12,5}, '{1,14,2,11,4,12,3,7,6,13,10,5,15,9,0,8},
      '{4,12,7,5,1,6,9,10,0,14,13,8,2,11,3,15}, '{11,9,5,1,12,3,13,14,6,4,7,15,2,0,8,10}}};
  int QORD [4][3] = '{'{0,0,1}, '{1,0,0}, '{0,1,1}, '{1,1,0}};
  int MDSR [4][4] = '{'{'h01,'hEF,'h5B,'h5B}, '{'h5B,'hEF,'hEF,'h01},
                      '{'hEF,'h5B,'h01,'hEF}, '{'hEF,'h01,'hEF,'h5B}};
  int qtab [2][256];
  logic [31:0] exp_e [20];
  logic [31:0] exp_o [20];

  function automatic int qperm(int q, int x);
    int a, b, ta, tb;
    a = x / 16;
    b = x % 16;
    for (int r = 0; r < 2; r++) begin
      ta = a ^ b;
      tb = a ^ ((b >> 1) | ((b & 1) << 3)) ^ ((8 * a) % 16);
      a  = QT[q][2*r][ta];
      b  = QT[q][2*r+1][tb];
    end
    return 16 * b + a;
  endfunction

  function automatic int gmul(int a, int b);
    int p = 0;
    while (b != 0) begin
      if ((b & 1) != 0) p = p ^ a;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h169;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] h_ref(int xb, logic [31:0] l0, logic [31:0] l1);
    int y [4];
    int acc;
    logic [31:0] z;
    for (int n = 0; n < 4; n++) begin
      y[n] = qtab[QORD[n][0]][xb];
      y[n] = qtab[QORD[n][1]][y[n] ^ int'(l1[8*n +: 8])];
      y[n] = qtab[QORD[n][2]][y[n] ^ int'(l0[8*n +: 8])];
    end
    for (int r = 0; r < 4; r++) begin
      acc = 0;
      for (int c = 0; c < 4; c++) acc = acc ^ gmul(MDSR[r][c], y[c]);
      z[8*r +: 8] = 8'(acc);
    end
    return z;
  endfunction

  task automatic compute_expected(input logic [127:0] kk);
    logic [31:0] a, b, t;
    for (int i = 0; i < 20; i++) begin
      a = h_ref(2*i,   kk[31:0],  kk[95:64]);
      b = h_ref(2*i+1, kk[63:32], kk[127:96]);
      b = (b << 8) | (b >> 24);
      exp_e[i] = a + b;
      t = a + (b << 1);
      exp_o[i] = (t << 9) | (t >> 23);
    end
  endtask

  // Full expansion; optional stall on one pair and a stray start during another
  task automatic expand(input logic [127:0] kk, input int stall_pair, input int stall_len, input int start_pair);
    int pair, n, stalled, last_hs, first_valid;
    compute_expected(kk);
    @(negedge clk); key = kk; start = 1'b1; k_ready = 1'b1;
    @(negedge clk); start = 1'b0; key = {$urandom, $urandom, $urandom, $urandom};
    n = 1; pair = 0; stalled = 0; last_hs = -1; first_valid = -1;
    while (pair < 20 && n < 400) begin
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL early_done cycle %0d: got %b want 0", n, done); end
      if (k_valid === 1'b1) begin
        if (first_valid < 0) first_valid = n;
        n_checks++; if (k_idx !== 5'(pair)) begin n_fail++; $display("FAIL k_idx cycle %0d: got %0d want %0d", n, k_idx, pair); end
        n_checks++; if (k_even !== exp_e[pair]) begin n_fail++; $display("FAIL k_even pair %0d: got %h want %h", pair, k_even, exp_e[pair]); end
        n_checks++; if (k_odd !== exp_o[pair]) begin n_fail++; $display("FAIL k_odd pair %0d: got %h want %h", pair, k_odd, exp_o[pair]); end
        if (pair == start_pair) begin start = 1'b1; key = {$urandom, $urandom, $urandom, $urandom}; end
        else start = 1'b0;
        if (pair == stall_pair && stalled < stall_len) begin k_ready = 1'b0; stalled++; end
        else begin k_ready = 1'b1; last_hs = n; pair++; end
      end else begin
        start = 1'b0;
        k_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk); n++;
    end
    start = 1'b0;
    n_checks++; if (pair != 20) begin n_fail++; $display("FAIL pair_timeout: got %0d pairs want 20", pair); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b want 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b want 0", busy); end
    n_checks++; if (first_valid != 3) begin n_fail++; $display("FAIL first_valid_cycle: got %0d want 3", first_valid); end
    n_checks++; if (last_hs != 60 + stalled) begin n_fail++; $display("FAIL last_handshake_cycle: got %0d want %0d", last_hs, 60 + stalled); end
    n_checks++; if (stalled != stall_len && stall_pair >= 0) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", stalled, stall_len); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b want 0", done); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (k_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_k_valid: got %b want 0", k_valid); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (k_idx !== 5'd0)    begin n_fail++; $display("FAIL reset_k_idx: got %0d want 0", k_idx); end
    n_checks++; if (k_even !== 32'd0)  begin n_fail++; $display("FAIL reset_k_even: got %h want 0", k_even); end
    n_checks++; if (k_odd !== 32'd0)   begin n_fail++; $display("FAIL reset_k_odd: got %h want 0", k_odd); end
    rst = 1'b0;
  endtask

  task automatic test_zero_key_kat();
    @(negedge clk); key = '0; start = 1'b1; k_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++; if (k_valid !== 1'b0) begin n_fail++; $display("FAIL kat_valid_c1: got %b want 0", k_valid); end
    @(negedge clk);
    n_checks++; if (k_valid !== 1'b0) begin n_fail++; $display("FAIL kat_valid_c2: got %b want 0", k_valid); end
    @(negedge clk);
    n_checks++; if (k_valid !== 1'b1) begin n_fail++; $display("FAIL kat_valid_c3: got %b want 1", k_valid); end
    n_checks++; if (k_even !== 32'h52C54DDE) begin n_fail++; $display("FAIL kat_k0: got %h want 52c54dde", k_even); end
    n_checks++; if (k_odd !== 32'h11F0626D) begin n_fail++; $display("FAIL kat_k1: got %h want 11f0626d", k_odd); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_full_run();
    expand('0, -1, 0, -1);
  endtask

  task automatic test_random_keys();
    for (int k = 0; k < 3; k++) expand({$urandom, $urandom, $urandom, $urandom}, -1, 0, -1);
  endtask

  task automatic test_stall();
    expand({$urandom, $urandom, $urandom, $urandom}, 7, 5, -1);
  endtask

  task automatic test_start_ignored();
    expand({$urandom, $urandom, $urandom, $urandom}, -1, 0, 3);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); key = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1; k_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 1; n < 32; n++) @(negedge clk);
    n_checks++; if (k_idx !== 5'd10) begin n_fail++; $display("FAIL mid_k_idx: got %0d want 10", k_idx); end
    n_checks++; if (busy !== 1'b1 || k_valid !== 1'b0) begin n_fail++; $display("FAIL mid_calc_b: got busy %b valid %b want 1 0", busy, k_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || k_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL async_ctrl: got busy %b valid %b done %b want 0 0 0", busy, k_valid, done); end
    n_checks++; if (k_idx !== 5'd0 || k_even !== 32'd0 || k_odd !== 32'd0) begin n_fail++; $display("FAIL async_data: got %0d %h %h want 0 0 0", k_idx, k_even, k_odd); end
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_quiet: got done %b busy %b want 0 0", done, busy); end
    end
    expand({$urandom, $urandom, $urandom, $urandom}, -1, 0, -1);
  endtask

  initial begin
    for (int q = 0; q < 2; q++)
      for (int x = 0; x < 256; x++) qtab[q][x] = qperm(q, x);
    test_reset();
    test_zero_key_kat();
    test_full_run();
    test_random_keys();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
